alarm_controller: RTL and testbench

- Parametrised, clocked successor to the combinational alarm block: ZONES sensor inputs, arm/disarm commands, timed exit and entry delays, and a timed siren.
- Per-zone entry-delay masking, auto-bypass of zones still open at re-arm, and a latched cause register.
- Sits between the sensor/keypad front end and the siren driver.
- Zone convention is unchanged: 1 = closed/secure, 0 = open.

---
 rtl/alarm_controller.sv | 217 +++++++++++++++++++++
 tb/tb_alarm_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// -----------------------------------------------------------------------------
// alarm_controller
//
// Clocked intruder-alarm controller. It takes ZONES sensor inputs
// (1 = closed/secure, 0 = open), arm/disarm requests and a panic level. It runs
// timed exit and entry delays and a timed siren. Zones that are still open when
// the siren times out are auto-bypassed until they first read closed again. A
// latched cause register records every zone that caused or joined an alarm.
//
// Optional build macro: ALARM_SYNC_EN
//   When defined, zone_i and panic_i each pass through a 2-flop synchroniser.
//   The zone synchroniser resets to all-closed and the panic synchroniser to 0.
//   This adds 2 cycles to every zone/panic response. arm_i and disarm_i are
//   used directly.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   panic_i        level; forces alarm from any state
//   arm_i          single-cycle arm request
//   disarm_i       single-cycle disarm request
//   zone_i         sensor states, 1 = closed
//   entry_mask_i   1 = delayed (entry) zone, 0 = instant zone; static
//   alarm_o        siren drive
//   armed_o        high in ARMED or ENTRY_DLY
//   arm_fault_o    one-cycle pulse: arm request rejected (zone open)
//   state_o        current state code (0..4)
//   alarm_zone_o   latched zones that caused or joined the alarm
// -----------------------------------------------------------------------------
module alarm_controller #(
    parameter int ZONES       = 4,
    parameter int CNT_W       = 8,
    parameter int EXIT_DELAY  = 16,
    parameter int ENTRY_DELAY = 8,
    parameter int SIREN_TIME  = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             panic_i,
    input  logic             arm_i,
    input  logic             disarm_i,
    input  logic [ZONES-1:0] zone_i,
    input  logic [ZONES-1:0] entry_mask_i,
    output logic             alarm_o,
    output logic             armed_o,
    output logic             arm_fault_o,
    output logic [2:0]       state_o,
    output logic [ZONES-1:0] alarm_zone_o
);

    typedef enum logic [2:0] {
        S_DISARMED  = 3'd0,
        S_EXIT_DLY  = 3'd1,
        S_ARMED     = 3'd2,
        S_ENTRY_DLY = 3'd3,
        S_ALARM     = 3'd4
    } state_t;

    // The counter counts down to 0 inclusive, so it is loaded with delay-1.
    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ZONES-1:0] bypass_q;
    logic [ZONES-1:0] alarm_zone_q;
    logic             alarm_q;
    logic             armed_q;
    logic             arm_fault_q;

    logic [ZONES-1:0] zone_s;
    logic             panic_s;

`ifdef ALARM_SYNC_EN
    logic [ZONES-1:0] zone_meta_q, zone_sync_q;
    logic             panic_meta_q, panic_sync_q;

    // Reset to "all closed, no panic" so that leaving reset does not look
    // like a zone opening.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            zone_meta_q  <= '1;
            zone_sync_q  <= '1;
            panic_meta_q <= 1'b0;
            panic_sync_q <= 1'b0;
        end else begin
            zone_meta_q  <= zone_i;
            zone_sync_q  <= zone_meta_q;
            panic_meta_q <= panic_i;
            panic_sync_q <= panic_meta_q;
        end
    end

    assign zone_s  = zone_sync_q;
    assign panic_s = panic_sync_q;
`else
    assign zone_s  = zone_i;
    assign panic_s = panic_i;
`endif

    // Zone classification. Bypassed zones never count as open.
    logic [ZONES-1:0] open_w, inst_w, dly_w;
    assign open_w = ~zone_s & ~bypass_q;
    assign inst_w = open_w & ~entry_mask_i;
    assign dly_w  = open_w & entry_mask_i;

    // Default next values. A bypass bit drops as soon as its zone reads
    // closed. The cause register accumulates whatever is open while the
    // controller enters or stays in alarm.
    logic [ZONES-1:0] bypass_d, alarm_zone_d;
    assign bypass_d     = bypass_q & ~zone_s;
    assign alarm_zone_d = alarm_zone_q | open_w;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_DISARMED;
            cnt_q        <= '0;
            bypass_q     <= '0;
            alarm_zone_q <= '0;
            alarm_q      <= 1'b0;
            armed_q      <= 1'b0;
            arm_fault_q  <= 1'b0;
        end else begin
            arm_fault_q <= 1'b0;
            bypass_q    <= bypass_d;

            if (panic_s) begin
                // Panic holds the siren on: the counter reloads every cycle
                // while the level is high.
                state_q      <= S_ALARM;
                cnt_q        <= SIREN_LOAD;
                alarm_q      <= 1'b1;
                armed_q      <= 1'b0;
                alarm_zone_q <= alarm_zone_d;
            end else if (disarm_i) begin
                state_q      <= S_DISARMED;
                cnt_q        <= '0;
                bypass_q     <= '0;
                alarm_zone_q <= '0;
                alarm_q      <= 1'b0;
                armed_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_DISARMED: begin
                        if (arm_i) begin
                            if (&zone_s) begin
                                state_q <= S_EXIT_DLY;
                                cnt_q   <= EXIT_LOAD;
                            end else begin
                                arm_fault_q <= 1'b1;
                            end
                        end
                    end
                    S_EXIT_DLY: begin
                        if (cnt_q == '0) begin
                            state_q <= S_ARMED;
                            armed_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (|inst_w) begin
                            state_q      <= S_ALARM;
                            cnt_q        <= SIREN_LOAD;
                            alarm_q      <= 1'b1;
                            armed_q      <= 1'b0;
                            alarm_zone_q <= alarm_zone_d;
                        end else if (|dly_w) begin
                            state_q <= S_ENTRY_DLY;
                            cnt_q   <= ENTRY_LOAD;
                        end
                    end
                    S_ENTRY_DLY: begin
                        // The delay is not aborted by the zone re-closing;
                        // only disarm (handled above) stops it.
                        if ((|inst_w) || (cnt_q == '0)) begin
                            state_q      <= S_ALARM;
                            cnt_q        <= SIREN_LOAD;
                            alarm_q      <= 1'b1;
                            armed_q      <= 1'b0;
                            alarm_zone_q <= alarm_zone_d;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_ALARM: begin
                        alarm_zone_q <= alarm_zone_d;
                        if (cnt_q == '0) begin
                            // Re-arm and bypass whatever is still open, so a
                            // door left open does not re-trigger immediately.
                            state_q  <= S_ARMED;
                            alarm_q  <= 1'b0;
                            armed_q  <= 1'b1;
                            bypass_q <= ~zone_s;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_DISARMED;
                        alarm_q <= 1'b0;
                        armed_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_o      = state_q;
    assign alarm_o      = alarm_q;
    assign armed_o      = armed_q;
    assign arm_fault_o  = arm_fault_q;
    assign alarm_zone_o = alarm_zone_q;

endmodule

// File: tb/tb_alarm_controller.sv
// -----------------------------------------------------------------------------
// tb_alarm_controller
//
// Table-driven bench for alarm_controller. It uses ZONES=4, EXIT_DELAY=4,
// ENTRY_DELAY=3, SIREN_TIME=5 and ENTRY_MASK=0001. Each table row is one clock
// cycle: the inputs are driven at a falling edge and the expected outputs are
// queued. After the next rising edge the outputs are compared at the following
// falling edge. The async-reset corner is checked by a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       panic = 1'b0;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;
    logic [3:0] zone = 4'hF;
    logic [3:0] entry_mask = 4'b0001;

    logic       alarm, armed, arm_fault;
    logic [2:0] state;
    logic [3:0] alarm_zone;

    alarm_controller #(
        .ZONES      (4),
        .CNT_W      (8),
        .EXIT_DELAY (4),
        .ENTRY_DELAY(3),
        .SIREN_TIME (5)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .panic_i     (panic),
        .arm_i       (arm),
        .disarm_i    (disarm),
        .zone_i      (zone),
        .entry_mask_i(entry_mask),
        .alarm_o     (alarm),
        .armed_o     (armed),
        .arm_fault_o (arm_fault),
        .state_o     (state),
        .alarm_zone_o(alarm_zone)
    );

    always #5 clk = ~clk;

    // exp packs {state[2:0], alarm, armed, arm_fault, alarm_zone[3:0]}
    typedef struct {
        logic       p;
        logic       a;
        logic       d;
        logic [3:0] z;
        logic [9:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [9:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    localparam logic [3:0] ZF = 4'b1111;
    localparam logic [3:0] ZE = 4'b1110;

    function automatic logic [9:0] outs();
        return {state, alarm, armed, arm_fault, alarm_zone};
    endfunction

    task automatic add(input logic p, input logic a, input logic d,
                       input logic [3:0] z, input logic [2:0] st,
                       input logic al, input logic am, input logic af,
                       input logic [3:0] az);
        vec_t v;
        v.p   = p;
        v.a   = a;
        v.d   = d;
        v.z   = z;
        v.exp = {st, al, am, af, az};
        vecs.push_back(v);
    endtask

    // Arm from DISARMED with all zones closed: 4 cycles of exit delay, then armed.
    task automatic add_arm();
        add(0, 1, 0, ZF, 3'd1, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 3; i++) add(0, 0, 0, ZF, 3'd1, 0, 0, 0, 4'b0000);
        add(0, 0, 0, ZF, 3'd2, 0, 1, 0, 4'b0000);
    endtask

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got st=%0d alarm=%b armed=%b fault=%b zones=%b, expected st=%0d alarm=%b armed=%b fault=%b zones=%b",
                     name, got[9:7], got[6], got[5], got[4], got[3:0],
                     exp[9:7], exp[6], exp[5], exp[4], exp[3:0]);
        end else begin
            $display("[TB] %s ok: st=%0d alarm=%b armed=%b fault=%b zones=%b",
                     name, got[9:7], got[6], got[5], got[4], got[3:0]);
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        panic  = v.p;
        arm    = v.a;
        disarm = v.d;
        zone   = v.z;
        exp_q.push_back(v.exp);
        @(negedge clk);
        check(name, outs(), exp_q.pop_front());
    endtask

    initial begin
        vec_t hv;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", outs(), 10'd0);
        rst_n = 1'b1;

        // Exit delay: state 1 for 4 cycles, then armed
        add_arm();
        // Disarm, then rejected arm with zone 2 open
        add(0, 0, 1, ZF,      3'd0, 0, 0, 0, 4'b0000);
        add(0, 1, 0, 4'b1011, 3'd0, 0, 0, 1, 4'b0000);
        add(0, 0, 0, 4'b1011, 3'd0, 0, 0, 0, 4'b0000);
        add(0, 0, 0, ZF,      3'd0, 0, 0, 0, 4'b0000);
        // Entry delay aborted by disarm
        add_arm();
        add(0, 0, 0, ZE, 3'd3, 0, 1, 0, 4'b0000);
        add(0, 0, 0, ZE, 3'd3, 0, 1, 0, 4'b0000);
        add(0, 0, 1, ZE, 3'd0, 0, 0, 0, 4'b0000);
        add(0, 0, 0, ZF, 3'd0, 0, 0, 0, 4'b0000);
        // Entry delay expires -> siren, re-arm with zone 0 bypassed
        add_arm();
        for (int i = 0; i < 3; i++) add(0, 0, 0, ZE, 3'd3, 0, 1, 0, 4'b0000);
        for (int i = 0; i < 5; i++) add(0, 0, 0, ZE, 3'd4, 1, 0, 0, 4'b0001);
        add(0, 0, 0, ZE, 3'd2, 0, 1, 0, 4'b0001);
        add(0, 0, 0, ZE, 3'd2, 0, 1, 0, 4'b0001);
        add(0, 0, 0, ZF, 3'd2, 0, 1, 0, 4'b0001);
        add(0, 0, 0, ZE, 3'd3, 0, 1, 0, 4'b0001);
        add(0, 0, 1, ZF, 3'd0, 0, 0, 0, 4'b0000);
        // Instant zone from ARMED
        add_arm();
        add(0, 0, 0, 4'b1101, 3'd4, 1, 0, 0, 4'b0010);
        add(0, 0, 1, ZF,      3'd0, 0, 0, 0, 4'b0000);
        // Instant zone during entry delay
        add_arm();
        add(0, 0, 0, ZE,      3'd3, 0, 1, 0, 4'b0000);
        add(0, 0, 0, 4'b1100, 3'd4, 1, 0, 0, 4'b0011);
        add(0, 0, 1, ZF,      3'd0, 0, 0, 0, 4'b0000);
        // One-cycle panic from DISARMED, then ARM ignored while armed
        add(1, 0, 0, ZF, 3'd4, 1, 0, 0, 4'b0000);
        for (int i = 0; i < 4; i++) add(0, 0, 0, ZF, 3'd4, 1, 0, 0, 4'b0000);
        add(0, 0, 0, ZF, 3'd2, 0, 1, 0, 4'b0000);
        add(0, 1, 0, ZF, 3'd2, 0, 1, 0, 4'b0000);
        add(0, 0, 1, ZF, 3'd0, 0, 0, 0, 4'b0000);
        // Panic and disarm together: panic wins
        add(1, 0, 1, ZF, 3'd4, 1, 0, 0, 4'b0000);
        add(0, 0, 0, ZF, 3'd4, 1, 0, 0, 4'b0000);
        add(0, 0, 0, ZF, 3'd4, 1, 0, 0, 4'b0000);

        foreach (vecs[i]) run_vec($sformatf("row%0d", i), vecs[i]);

        // Asynchronous reset mid-siren, away from any clock edge
        #2 rst_n = 1'b0;
        #1 check("async_reset", outs(), 10'd0);
        @(negedge clk);
        check("reset_held", outs(), 10'd0);
        rst_n = 1'b1;

        // Controller is usable again after reset
        hv.p = 0; hv.a = 1; hv.d = 0; hv.z = ZF; hv.exp = {3'd1, 1'b0, 1'b0, 1'b0, 4'b0000};
        run_vec("post_reset_arm", hv);
        hv.a = 0;
        run_vec("post_reset_exit", hv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
